uart_tx_port: RTL

- Memory-mapped UART transmitter on the CPU byte bus.
- Sits directly downstream of the CPU and consumes its ST traffic: single-cycle write strobe, 16-bit address, 8-bit write data.
- Returns status bytes on the CPU read path with one-cycle latency.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on tx.

---
 rtl/uart_tx_port_pkg.sv | 38 +++
 rtl/uart_tx_port_if.sv | 22 ++
 rtl/uart_tx_port_sync_fifo.sv | 70 +++++++
 rtl/uart_tx_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_port_pkg.sv
// Shared constants for the UART transmit port: register offsets, STATUS/CTRL
// bit positions, TX FSM state encodings and a STATUS byte builder.
package uart_tx_port_pkg;

  // Register offsets from the port base address
  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR_OVF = 3;

  // TX FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                             input logic busy, input logic ovf);
    logic [7:0] s;
    s              = 8'h00;
    s[STAT_FULL]   = full;
    s[STAT_EMPTY]  = empty;
    s[STAT_BUSY]   = busy;
    s[STAT_OVF]    = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU byte-bus connection seen by memory-mapped peripherals: single-cycle
// write strobe, 16-bit address, 8-bit write data, registered read return.
interface uart_tx_port_if;
  import uart_tx_port_pkg::*;

  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic        bus_hit;

  modport master (
    output bus_addr, bus_wdata, bus_we,
    input  bus_rdata, bus_hit
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we,
    output bus_rdata, bus_hit
  );

endinterface

// File: rtl/uart_tx_port_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push while full is accepted
// only when a pop frees the slot in the same cycle; pops while empty are ignored.
module sync_fifo
  import uart_tx_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok = pop_i && !empty_o;
  assign wr_ok  = push_i && (!full_o || pop_ok);

  // Next pointers and occupancy from the accepted push/pop pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter. CPU stores to DATA fill a FIFO; the TX
// FSM drains it LSB first on a registered tx line. STATUS/CTRL are readable
// with one cycle of latency, alongside a registered address-hit flag.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_port_if.slave bus,
  output logic          tx,
  output logic          fifo_empty
);

  localparam int                 BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam int                 CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  // Address decode: wrap-safe offset from the base
  logic [15:0] offset;
  logic        in_range;
  logic [1:0]  reg_sel;
  logic        push;
  logic        ctrl_wr;

  assign offset   = bus.bus_addr - BASE_ADDR;
  assign in_range = (offset < 16'd4);
  assign reg_sel  = offset[1:0];
  assign push     = bus.bus_we && in_range && (reg_sel == UART_DATA);
  assign ctrl_wr  = bus.bus_we && in_range && (reg_sel == UART_CTRL);

  // FIFO
  logic             pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty_w;
  logic [CNT_W-1:0] fifo_cnt;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (bus.bus_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty_w),
    .count_o (fifo_cnt)
  );

  assign fifo_empty = fifo_empty_w;

  // Control/status registers
  logic enable_q;
  logic ovf_q;
  logic ovf_set;

  // A push is dropped only when the FIFO is full and nothing leaves this cycle
  assign ovf_set = push && (fifo_cnt == CNT_W'(FIFO_DEPTH)) && !pop;

  // Enable bit and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (ctrl_wr) enable_q <= bus.bus_wdata[CTRL_EN];
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (ctrl_wr && bus.bus_wdata[CTRL_CLR_OVF])
        ovf_q <= 1'b0;
    end
  end

  // TX FSM registers
  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy;

  assign busy = (state_q != ST_IDLE);
  assign tx   = tx_q;

  // Read path: sample address this cycle, present data and hit next cycle
  logic [7:0] rdata_q, rdata_d;
  logic       hit_q;

  // Read data mux over the register map
  always_comb begin
    rdata_d = 8'h00;
    if (in_range) begin
      unique case (reg_sel)
        UART_STATUS: rdata_d = status_byte(fifo_full, fifo_empty_w, busy, ovf_q);
        UART_CTRL:   rdata_d = {7'b0, enable_q};
        default:     rdata_d = 8'h00;
      endcase
    end
  end

  // Registered read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 8'h00;
      hit_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      hit_q   <= in_range;
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_hit   = hit_q;

  // Next-state logic; tx_d is the line level for the state being entered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (enable_q && !fifo_empty_w) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = BAUD_RELOAD;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FSM control state and the tx flop; reset forces the line idle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register holds frame data only
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
